// File: rtl/stateful_lanes.sv
// rtl/stateful_lanes.sv - LANES independent strobe-edge-updated registers with change pulses and saturating edge count
module stateful_lanes #(
  parameter int                LANES  = 2,
  parameter int                LANE_W = 2,
  parameter int                CNT_W  = 8,
  parameter logic [LANE_W-1:0] INIT   = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*LANE_W-1:0]   data_in,
  input  logic [LANES-1:0]          strobe,
  input  logic [1:0]                mode,
  output logic [LANES*LANE_W-1:0]   data_out,
  output logic [LANES-1:0]          changed,
  output logic [CNT_W-1:0]          strobe_count
);

  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_XOR  = 2'd1;
  localparam logic [1:0] MODE_ADD  = 2'd2;
  // Sum is wide enough that adding every lane at once cannot overflow before saturation.
  localparam int         SW        = CNT_W + $clog2(LANES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LANES*LANE_W-1:0] data_q, data_d;
  logic [LANES-1:0]        changed_q, changed_d;
  logic [LANES-1:0]        strobe_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]           pop;
  logic [SW-1:0]           sum;
  logic [LANE_W-1:0]       old_v, opd_v, new_v;

  always_comb begin
    data_d    = data_q;
    changed_d = '0;
    pop       = '0;
    old_v     = '0;
    opd_v     = '0;
    new_v     = '0;
    for (int i = 0; i < LANES; i++) begin
      old_v = data_q[i*LANE_W +: LANE_W];
      opd_v = data_in[i*LANE_W +: LANE_W];
      case (mode)
        MODE_LOAD: new_v = opd_v;
        MODE_XOR:  new_v = old_v ^ opd_v;
        MODE_ADD:  new_v = old_v + opd_v;
        default:   new_v = '0;
      endcase
      if (strobe[i] && !strobe_q[i]) begin
        data_d[i*LANE_W +: LANE_W] = new_v;
        changed_d[i]               = (new_v != old_v);
        pop                        = pop + SW'(1);
      end
    end
    sum   = SW'(cnt_q) + pop;
    cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  // strobe_q resets high so a strobe held through reset must drop before it can fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= {LANES{INIT}};
      changed_q <= '0;
      strobe_q  <= '1;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      changed_q <= changed_d;
      strobe_q  <= strobe;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out     = data_q;
  assign changed      = changed_q;
  assign strobe_count = cnt_q;

endmodule

// File: tb/tb_stateful_lanes.sv
// tb/tb_stateful_lanes.sv - directed self-checking bench for stateful_lanes
module tb_stateful_lanes;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic [1:0] strobe;
  logic [1:0] mode;
  logic [3:0] data_out;
  logic [1:0] changed;
  logic [7:0] strobe_count;

  logic       reset_s;
  logic [3:0] data_in_s;
  logic [1:0] strobe_s;
  logic [1:0] mode_s;
  logic [3:0] data_out_s;
  logic [1:0] changed_s;
  logic [1:0] strobe_count_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stateful_lanes u_dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .strobe       (strobe),
    .mode         (mode),
    .data_out     (data_out),
    .changed      (changed),
    .strobe_count (strobe_count)
  );

  stateful_lanes #(.CNT_W(2)) u_sat (
    .clk          (clk),
    .reset        (reset_s),
    .data_in      (data_in_s),
    .strobe       (strobe_s),
    .mode         (mode_s),
    .data_out     (data_out_s),
    .changed      (changed_s),
    .strobe_count (strobe_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_out, input logic [1:0] e_ch,
                           input logic [7:0] e_cnt);
    check({tag, " data_out"}, 32'(data_out), 32'(e_out));
    check({tag, " changed"}, 32'(changed), 32'(e_ch));
    check({tag, " count"}, 32'(strobe_count), 32'(e_cnt));
  endtask

  task automatic pulse(input string tag, input logic [1:0] s, input logic [1:0] m,
                       input logic [3:0] d, input logic [3:0] e_out, input logic [1:0] e_ch,
                       input logic [7:0] e_cnt);
    strobe  = s;
    mode    = m;
    data_in = d;
    step();
    check_all(tag, e_out, e_ch, e_cnt);
    strobe  = 2'b00;
    data_in = 4'hx;
    mode    = 2'bxx;
    step();
    check({tag, " pulse end"}, 32'(changed), 32'(0));
  endtask

  task automatic sat_pulse(input string tag, input logic [1:0] s, input logic [1:0] e_cnt);
    strobe_s = s;
    step();
    check(tag, 32'(strobe_count_s), 32'(e_cnt));
    strobe_s = 2'b00;
    step();
  endtask

  initial begin
    reset = 1'b1; strobe = 2'b11; mode = 2'd0; data_in = 4'h0;
    reset_s = 1'b1; strobe_s = 2'b00; mode_s = 2'd0; data_in_s = 4'h0;

    step();
    step();
    check_all("reset", 4'h0, 2'b00, 8'd0);
    reset = 1'b0;
    data_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("held high", 4'h0, 2'b00, 8'd0);
    end
    strobe = 2'b00;
    step();
    check_all("strobe low", 4'h0, 2'b00, 8'd0);
    pulse("dual edge", 2'b11, 2'd0, 4'b1001, 4'b1001, 2'b11, 8'd2);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_all("rereset", 4'h0, 2'b00, 8'd0);

    pulse("load same", 2'b01, 2'd0, 4'b0000, 4'b0000, 2'b00, 8'd1);
    pulse("load 01",   2'b01, 2'd0, 4'b0001, 4'b0001, 2'b01, 8'd2);
    pulse("load 11",   2'b01, 2'd0, 4'b1111, 4'b0011, 2'b01, 8'd3);
    pulse("load l1",   2'b10, 2'd0, 4'b1111, 4'b1111, 2'b10, 8'd4);
    pulse("load l1 01", 2'b10, 2'd0, 4'b0111, 4'b0111, 2'b10, 8'd5);

    pulse("set 01",    2'b01, 2'd0, 4'b1101, 4'b0101, 2'b01, 8'd6);
    pulse("xor",       2'b01, 2'd1, 4'b1111, 4'b0110, 2'b01, 8'd7);
    pulse("add wrap",  2'b01, 2'd2, 4'b0010, 4'b0100, 2'b01, 8'd8);
    pulse("set 11",    2'b01, 2'd0, 4'b0011, 4'b0111, 2'b01, 8'd9);
    pulse("add 3+1",   2'b01, 2'd2, 4'b0001, 4'b0100, 2'b01, 8'd10);
    pulse("clear 0",   2'b01, 2'd3, 4'b1111, 4'b0100, 2'b00, 8'd11);
    pulse("clear l1",  2'b10, 2'd3, 4'b1111, 4'b0000, 2'b10, 8'd12);

    strobe = 2'b01; mode = 2'd0; data_in = 4'b0010;
    step();
    check_all("hold first", 4'b0010, 2'b01, 8'd13);
    data_in = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      step();
      check_all("hold again", 4'b0010, 2'b00, 8'd13);
    end

    strobe = 2'b00;
    step();
    strobe = 2'b11; mode = 2'd0; data_in = 4'b1111; reset = 1'b1;
    step();
    check_all("mid reset", 4'h0, 2'b00, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_all("post reset", 4'h0, 2'b00, 8'd0);
    end
    strobe = 2'b00;

    reset_s = 1'b0;
    step();
    check("sat reset", 32'(strobe_count_s), 32'(0));
    sat_pulse("sat 1", 2'b01, 2'd1);
    sat_pulse("sat 2", 2'b01, 2'd2);
    sat_pulse("sat 3", 2'b01, 2'd3);
    sat_pulse("sat 4", 2'b01, 2'd3);
    sat_pulse("sat dual", 2'b11, 2'd3);
    step();
    check("sat stays", 32'(strobe_count_s), 32'(3));

    reset_s = 1'b1;
    step();
    reset_s = 1'b0;
    step();
    sat_pulse("sat b1", 2'b10, 2'd1);
    sat_pulse("sat b2", 2'b10, 2'd2);
    sat_pulse("sat b dual", 2'b11, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stateful_lanes.md
# stateful_lanes

Parametrised successor to the two-lane strobed state register used in the logic-analyzer demo. It holds LANES independent registers of LANE_W bits each. A rising edge on a lane's strobe updates that lane from its slice of data_in under a shared operation mode: load, XOR, add or clear. It also emits per-lane change pulses and a saturating count of accepted strobe edges, giving the analyzer richer state to capture.

## Interface
Parameters:
- LANES, 2, number of independent lanes (≥1)
- LANE_W, 2, bits per lane (≥1)
- CNT_W, 8, width of strobe_count (≥2)
- INIT, 0, reset value of every lane (LANE_W bits, replicated per lane)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_in  input  LANES*LANE_W  lane i operand is data_in[i*LANE_W +: LANE_W]
- strobe  input  LANES  per-lane update request, level; acts on rising edge only
- mode  input  2  operation applied on an accepted edge: 0 LOAD, 1 XOR, 2 ADD, 3 CLEAR
- data_out  output  LANES*LANE_W  registered lane values, same slicing as data_in
- changed  output  LANES  one-cycle pulse per lane whose value changed at the last edge
- strobe_count  output  CNT_W  total accepted strobe edges, saturating

## Operation
- Each cycle, strobe is registered into strobe_q.
- Lane i has an accepted edge when strobe[i]=1 and strobe_q[i]=0.
- On an accepted edge, lane i becomes f(mode, lane_i, d_i):
  - LOAD: d_i
  - XOR: lane_i ^ d_i
  - ADD: (lane_i + d_i) mod 2^LANE_W, carry discarded
  - CLEAR: 0
- Without an accepted edge, the lane holds. A held-high strobe produces exactly one update.
- changed[i] is registered: 1 only if lane i had an accepted edge and its new value differs from its old value. A LOAD of an identical value gives changed=0.
- strobe_count increments by the popcount of accepted edges in the cycle. It saturates at 2^CNT_W−1 and never wraps.
- Lanes are fully independent. Simultaneous edges on several lanes all apply in the same cycle, using the same mode.
- mode and data_in are sampled only on the cycle of the accepted edge. Values on other cycles are don't-care.

## Timing
- Reset (reset=1 at a posedge), which overrides all other activity:
  - data_out = INIT per lane
  - changed = 0
  - strobe_count = 0
  - strobe_q = all ones, so a strobe held high through reset does not fire until it has been low for at least one cycle
- Latency:
  - Strobe sampled high at posedge k (low at posedge k−1): data_out is updated after posedge k.
  - changed is valid in the same cycle as the new data_out, for exactly one cycle.
  - strobe_count reflects the edge after posedge k.
- Minimum strobe pulse: high for 1 cycle, then low for 1 cycle before the next edge. Back-to-back edges on a lane are therefore at most one every 2 cycles.
- Strobe pulses shorter than a clock period between posedges are not seen (no asynchronous capture).
- Reset asserted mid-sequence discards any edge sampled in that cycle.
- Saturation boundary: at count 2^CNT_W−2 with 2 simultaneous edges, the result is 2^CNT_W−1, not a wrap.
- ADD boundary: with LANE_W=2, lane 3 + 1 gives 0 and changed=1.

## Test plan
- Reset and hold:
  - Stimulus: reset for 2 cycles with strobe=2'b11, release reset, keep strobe high for 3 cycles.
  - Required: data_out=0, changed=0 and strobe_count=0 throughout. After strobe goes low then high, one update occurs.
- LOAD sequence (LANES=2, LANE_W=2), all with mode=0:
  - Pulse strobe[0] with data_in=0000: data_out=0000, changed=00.
  - Set data_in=0001 and pulse strobe[0]: data_out=0001, changed=01.
  - Set data_in=1111 and pulse strobe[0]: data_out=0011, changed=01.
  - Pulse strobe[1]: data_out=1111, changed=10.
  - Set data_in=0111 and pulse strobe[1]: data_out=0111.
  - After the sequence, strobe_count=5.
- XOR and ADD:
  - Lane0=01. mode=1 with d=11: lane0 becomes 10.
  - mode=2 with d=10: lane0 becomes 00 (wrap), changed[0]=1.
  - mode=3: lane0 becomes 00, changed[0]=0.
- Simultaneous lanes:
  - Stimulus: strobe 00→11 in one cycle, mode=0, data_in=1001.
  - Required: data_out=1001 after one posedge, changed=11, strobe_count +2.
- Saturation (CNT_W=2):
  - Stimulus: 4 single edges, then one dual edge.
  - Required: strobe_count goes 1, 2, 3, 3, then stays at 3.
- Mid-operation reset:
  - Stimulus: assert reset in the same cycle as a strobe edge with mode=0 and d=11.
  - Required: data_out=INIT, changed=0, strobe_count=0. No update appears after reset is released while strobe is still high.
